// File: rtl/knap_pkg.sv
// ---------------------------------------------------------------------------
// knap_pkg
// Shared types and helpers for the knapsack subset search.
//   knap_state_e : search controller states
//   knap_item_t  : one (value, weight) table entry at the default widths
//   calc_sum_w   : width of totals/thresholds. The extra bits let the
//                  all-ones mask be summed without overflow.
// ---------------------------------------------------------------------------
package knap_pkg;

   localparam int KNAP_VAL_W = 8;
   localparam int KNAP_WT_W  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } knap_state_e;

   typedef struct packed {
      logic [KNAP_VAL_W-1:0] value;
      logic [KNAP_WT_W-1:0]  weight;
   } knap_item_t;

   function automatic int calc_sum_w(input int n, input int vw, input int ww);
      return ((vw > ww) ? vw : ww) + $clog2(n + 1);
   endfunction

endpackage

// File: rtl/knap_search_eval.sv
// ---------------------------------------------------------------------------
// knap_eval
// Purely combinational masked sum: total_value / total_weight are the sums
// of the item values / weights whose mask bit is set. Shared between the
// search pipeline and the stand-alone combinational validity checker.
// Ports:
//   mask         in  N_ITEMS        subset, bit i selects item i
//   values       in  VAL_W x N      item values
//   weights      in  WT_W  x N      item weights
//   total_value  out SUM_W          sum of selected values
//   total_weight out SUM_W          sum of selected weights
// ---------------------------------------------------------------------------
module knap_eval
   import knap_pkg::*;
#(
   parameter int N_ITEMS = 5,
   parameter int VAL_W   = 8,
   parameter int WT_W    = 8,
   parameter int SUM_W   = calc_sum_w(N_ITEMS, VAL_W, WT_W)
) (
   input  logic [N_ITEMS-1:0] mask,
   input  logic [VAL_W-1:0]   values  [N_ITEMS],
   input  logic [WT_W-1:0]    weights [N_ITEMS],
   output logic [SUM_W-1:0]   total_value,
   output logic [SUM_W-1:0]   total_weight
);

   always_comb begin
      total_value  = '0;
      total_weight = '0;
      for (int i = 0; i < N_ITEMS; i++) begin
         if (mask[i]) begin
            total_value  = total_value  + SUM_W'(values[i]);
            total_weight = total_weight + SUM_W'(weights[i]);
         end
      end
   end

endmodule

// File: rtl/knap_search.sv
// ---------------------------------------------------------------------------
// knap_search
// Sequential knapsack search. Enumerates every subset mask of a loadable
// item table, one mask per cycle, through a two-stage pipeline
// (stage 1: masked totals, stage 2: feasibility test and best update), and
// reports the best feasible subset plus the number of feasible subsets.
// Optional build macro KNAP_EARLY_EXIT_EN: stop at the first feasible subset.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   item_we/idx/value/weight  item table write port (ignored while busy)
//   min_value, max_weight     feasibility thresholds, sampled at start
//   start              start request (ignored while busy or in DONE)
//   busy               search in progress
//   done               one-cycle pulse when results are final
//   found, best_mask, best_value, best_weight, valid_count   results
// ---------------------------------------------------------------------------
module knap_search
   import knap_pkg::*;
#(
   parameter int N_ITEMS = 5,
   parameter int VAL_W   = 8,
   parameter int WT_W    = 8,
   localparam int SUM_W  = calc_sum_w(N_ITEMS, VAL_W, WT_W),
   localparam int IDX_W  = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               item_we,
   input  logic [IDX_W-1:0]   item_idx,
   input  logic [VAL_W-1:0]   item_value,
   input  logic [WT_W-1:0]    item_weight,
   input  logic [SUM_W-1:0]   min_value,
   input  logic [SUM_W-1:0]   max_weight,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               found,
   output logic [N_ITEMS-1:0] best_mask,
   output logic [SUM_W-1:0]   best_value,
   output logic [SUM_W-1:0]   best_weight,
   output logic [N_ITEMS:0]   valid_count
);

   knap_state_e          state_q;
   logic [N_ITEMS-1:0]   mask_q;
   logic [SUM_W-1:0]     min_val_q;
   logic [SUM_W-1:0]     max_wt_q;
   logic [VAL_W-1:0]     tbl_val [N_ITEMS];
   logic [WT_W-1:0]      tbl_wt  [N_ITEMS];

   logic [SUM_W-1:0]     sum_val;
   logic [SUM_W-1:0]     sum_wt;
   logic [SUM_W-1:0]     tot_val_p1;
   logic [SUM_W-1:0]     tot_wt_p1;
   logic [N_ITEMS-1:0]   mask_p1;
   logic                 vld_p1;
   logic                 vld_p2;
   logic                 feas_p1;

   // Item table: frozen while a search is running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_ITEMS; i++) begin
            tbl_val[i] <= '0;
            tbl_wt[i]  <= '0;
         end
      end else if (item_we && !busy && (int'(item_idx) < N_ITEMS)) begin
         tbl_val[item_idx] <= item_value;
         tbl_wt[item_idx]  <= item_weight;
      end
   end

   // ---- stage 1: masked totals of the issued mask ----
   knap_eval #(
      .N_ITEMS (N_ITEMS),
      .VAL_W   (VAL_W),
      .WT_W    (WT_W),
      .SUM_W   (SUM_W)
   ) u_eval (
      .mask         (mask_q),
      .values       (tbl_val),
      .weights      (tbl_wt),
      .total_value  (sum_val),
      .total_weight (sum_wt)
   );

   always_ff @(posedge clk) begin
      tot_val_p1 <= sum_val;
      tot_wt_p1  <= sum_wt;
      mask_p1    <= mask_q;
   end

   // ---- stage 2: feasibility test and result update ----
   assign feas_p1 = (tot_val_p1 >= min_val_q) && (tot_wt_p1 <= max_wt_q);

`ifndef KNAP_EARLY_EXIT_EN
   // Masks arrive in ascending order, so a strict comparison keeps the
   // lower mask on a full tie.
   logic better_p1;
   assign better_p1 = !found || (tot_val_p1 > best_value) ||
                      ((tot_val_p1 == best_value) && (tot_wt_p1 < best_weight));
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mask_q      <= '0;
         min_val_q   <= '0;
         max_wt_q    <= '0;
         vld_p1      <= 1'b0;
         vld_p2      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         found       <= 1'b0;
         best_mask   <= '0;
         best_value  <= '0;
         best_weight <= '0;
         valid_count <= '0;
      end else begin
         done   <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= vld_p1;

         case (state_q)
            IDLE: begin
               if (start) begin
                  min_val_q   <= min_value;
                  max_wt_q    <= max_weight;
                  found       <= 1'b0;
                  best_mask   <= '0;
                  best_value  <= '0;
                  best_weight <= '0;
                  valid_count <= '0;
                  mask_q      <= '0;
                  busy        <= 1'b1;
                  state_q     <= RUN;
               end
            end
            RUN: begin
               vld_p1 <= 1'b1;
               mask_q <= mask_q + 1'b1;
               if (&mask_q) state_q <= DRAIN;
            end
            DRAIN: begin
               if (!vld_p1 && !vld_p2) begin
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state_q <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase

`ifdef KNAP_EARLY_EXIT_EN
         // First hit wins; empty both stages so DRAIN exits next cycle.
         if (vld_p1 && feas_p1 && !found) begin
            found       <= 1'b1;
            best_mask   <= mask_p1;
            best_value  <= tot_val_p1;
            best_weight <= tot_wt_p1;
            valid_count <= (N_ITEMS+1)'(1);
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            state_q     <= DRAIN;
         end
`else
         if (vld_p1 && feas_p1) begin
            valid_count <= valid_count + 1'b1;
            found       <= 1'b1;
            if (better_p1) begin
               best_mask   <= mask_p1;
               best_value  <= tot_val_p1;
               best_weight <= tot_wt_p1;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_knap_search.sv
module tb_knap_search;
   import knap_pkg::*;

   localparam int N  = 5;
   localparam int SW = calc_sum_w(N, 8, 8);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          item_we = 1'b0;
   logic [2:0]    item_idx = '0;
   logic [7:0]    item_value = '0;
   logic [7:0]    item_weight = '0;
   logic [SW-1:0] min_value = '0;
   logic [SW-1:0] max_weight = '0;
   logic          start = 1'b0;
   logic          busy, done, found;
   logic [N-1:0]  best_mask;
   logic [SW-1:0] best_value, best_weight;
   logic [N:0]    valid_count;

   int errors = 0;
   int checks = 0;

   knap_item_t tbl [N];
   int exp_found, exp_mask, exp_val, exp_wt, exp_cnt, exp_lat;

   knap_search #(.N_ITEMS(N), .VAL_W(8), .WT_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .item_we     (item_we),
      .item_idx    (item_idx),
      .item_value  (item_value),
      .item_weight (item_weight),
      .min_value   (min_value),
      .max_weight  (max_weight),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .found       (found),
      .best_mask   (best_mask),
      .best_value  (best_value),
      .best_weight (best_weight),
      .valid_count (valid_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: enumerate all subsets, pick highest value, then lowest
   // weight, then lowest mask.
   task automatic compute_model(input int mn, input int mx);
      int v, w;
      exp_found = 0; exp_mask = 0; exp_val = 0; exp_wt = 0; exp_cnt = 0;
      exp_lat = (1 << N) + 3;
      for (int m = 0; m < (1 << N); m++) begin
         v = 0; w = 0;
         for (int i = 0; i < N; i++)
            if (((m >> i) & 1) == 1) begin
               v += int'(tbl[i].value);
               w += int'(tbl[i].weight);
            end
         if (v >= mn && w <= mx) begin
`ifdef KNAP_EARLY_EXIT_EN
            if (exp_found == 0) begin
               exp_found = 1; exp_mask = m; exp_val = v; exp_wt = w;
               exp_cnt = 1; exp_lat = m + 3;
            end
`else
            exp_cnt++;
            if (exp_found == 0 || v > exp_val || (v == exp_val && w < exp_wt)) begin
               exp_mask = m; exp_val = v; exp_wt = w;
            end
            exp_found = 1;
`endif
         end
      end
   endtask

   task automatic load_item(input int idx, input int v, input int w);
      item_we = 1'b1; item_idx = 3'(idx); item_value = 8'(v); item_weight = 8'(w);
      tick();
      item_we = 1'b0;
      if (idx < N) begin
         tbl[idx].value  = 8'(v);
         tbl[idx].weight = 8'(w);
      end
   endtask

   task automatic load_table(input int v0, v1, v2, v3, v4, w0, w1, w2, w3, w4);
      load_item(0, v0, w0); load_item(1, v1, w1); load_item(2, v2, w2);
      load_item(3, v3, w3); load_item(4, v4, w4);
   endtask

   task automatic check_results(input string name);
      checks++;
      if (found !== (exp_found != 0)) begin
         errors++; $display("FAIL %s found: got %0d want %0d", name, found, exp_found);
      end
      checks++;
      if (best_mask !== N'(exp_mask)) begin
         errors++; $display("FAIL %s best_mask: got %b want %b", name, best_mask, N'(exp_mask));
      end
      checks++;
      if (best_value !== SW'(exp_val)) begin
         errors++; $display("FAIL %s best_value: got %0d want %0d", name, best_value, exp_val);
      end
      checks++;
      if (best_weight !== SW'(exp_wt)) begin
         errors++; $display("FAIL %s best_weight: got %0d want %0d", name, best_weight, exp_wt);
      end
      checks++;
      if (valid_count !== (N+1)'(exp_cnt)) begin
         errors++; $display("FAIL %s valid_count: got %0d want %0d", name, valid_count, exp_cnt);
      end
   endtask

   task automatic run_check(input string name, input int mn, input int mx);
      int cyc;
      compute_model(mn, mx);
      min_value = SW'(mn); max_weight = SW'(mx);
      start = 1'b1;
      tick();
      start = 1'b0;
      // thresholds must have been captured at start
      min_value = '1; max_weight = '0;
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL %s busy_after_start: got %b want 1", name, busy);
      end
      cyc = 0;
      while (done !== 1'b1 && cyc < 200) begin
         tick();
         cyc++;
      end
      checks++;
      if (cyc != exp_lat) begin
         errors++; $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
      end
      check_results(name);
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL %s after_done: got done=%b busy=%b want 0 0", name, done, busy);
      end
      tick(); tick();
      check_results({name, "_hold"});
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      checks++;
      if ({busy, done, found, best_mask, best_value, best_weight, valid_count} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b found=%b mask=%b val=%0d wt=%0d cnt=%0d want all 0",
                  busy, done, found, best_mask, best_value, best_weight, valid_count);
      end
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < N; i++) tbl[i] = '0;
      run_check("cleared_table", 0, 0);
   endtask

   task automatic test_directed();
      load_table(4, 2, 2, 1, 10, 12, 1, 2, 1, 4);
      run_check("plan_basic", 15, 16);
      run_check("plan_none", 16, 16);
      run_check("plan_empty_only", 0, 0);
      load_table(1, 1, 1, 1, 1, 1, 1, 1, 1, 1);
      run_check("plan_tie", 0, 2);
      run_check("all_feasible", 0, 1000);
   endtask

   task automatic test_random();
      int mn, mx;
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < N; i++)
            load_item(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
         mn = int'($urandom_range(0, 40));
         mx = int'($urandom_range(0, 40));
         run_check($sformatf("random%0d", t), mn, mx);
      end
   endtask

   task automatic test_busy_ignore();
      int cyc, pulses, first;
      load_table(4, 2, 2, 1, 10, 12, 1, 2, 1, 4);
      load_item(6, 200, 0);   // out-of-range index: must not land anywhere
      compute_model(15, 16);
      min_value = SW'(15); max_weight = SW'(16);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      start = 1'b1; item_we = 1'b1; item_idx = 3'd4; item_value = 8'd0; item_weight = 8'd0;
      tick();
      start = 1'b0; item_we = 1'b0;
      cyc = 6; pulses = 0; first = -1;
      for (int k = 0; k < 80; k++) begin
         if (done === 1'b1) begin
            pulses++;
            if (first < 0) begin
               first = cyc;
               check_results("busy_ignore");
            end
         end
         tick();
         cyc++;
      end
      checks++;
      if (pulses != 1) begin
         errors++; $display("FAIL busy_ignore pulses: got %0d want 1", pulses);
      end
      checks++;
      if (first != exp_lat) begin
         errors++; $display("FAIL busy_ignore latency: got %0d want %0d", first, exp_lat);
      end
      run_check("table_unchanged", 15, 16);
   endtask

   task automatic test_reset_mid_run();
      int pulses;
      load_table(1, 2, 3, 4, 5, 1, 1, 1, 1, 1);
      min_value = '0; max_weight = SW'(100);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      checks++;
      if (busy !== 1'b1 || found !== 1'b1) begin
         errors++; $display("FAIL midrun_pre_reset: got busy=%b found=%b want 1 1", busy, found);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, found, best_mask, best_value, best_weight, valid_count} !== '0) begin
         errors++;
         $display("FAIL async_reset_outputs: got busy=%b found=%b mask=%b val=%0d cnt=%0d want all 0",
                  busy, found, best_mask, best_value, valid_count);
      end
      repeat (2) tick();
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) tbl[i] = '0;
      pulses = 0;
      for (int k = 0; k < 50; k++) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++; $display("FAIL no_done_after_reset: got %0d active cycles want 0", pulses);
      end
      run_check("post_reset_cleared", 1, 0);
   endtask

   initial begin
      for (int i = 0; i < N; i++) tbl[i] = '0;
      test_reset();
      test_directed();
      test_random();
      test_busy_ignore();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
